result_burst_stats: RTL and testbench
=====================================

Name: result_burst_stats

Overview:
- Sits directly downstream of the lab05_3 result stage.
- Consumes its out_valid/out_result stream, one signed 7-bit result per valid cycle.
- Groups consecutive valid cycles into bursts and computes per-burst statistics: count, sum, max, min.
- Buffers finished records in a 2-entry queue and presents them on a valid/ready interface, so a slow consumer does not stall the upstream stage, which has no ready.

Parameters:
- DATA_W, 7: width of a signed input result.
- CNT_W, 5: burst-count width. Maximum burst length is 2^CNT_W-1 = 31.
- QDEPTH, 2: record-queue depth.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream out_valid.
- in_result  in  DATA_W  signed; upstream out_result.
- out_valid  out  1  record available at queue head.
- out_ready  in  1  consumer accepts head record.
- out_count  out  CNT_W  samples in burst, unsigned.
- out_sum  out  DATA_W+CNT_W  signed burst sum (12 bits at defaults).
- out_max  out  DATA_W  signed burst maximum.
- out_min  out  DATA_W  signed burst minimum.
- overflow  out  1  sticky; a record was dropped on a full queue.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears state to IDLE, clears the accumulators and the queue.
  - out_valid=0, out_count/out_sum/out_max/out_min=0, overflow=0.
  - A partial burst is discarded; no record is pushed.
- FSM states: IDLE, ACCUM.
  - IDLE & in_valid=1: count=1, sum=sign-extend(in_result), max=min=in_result; go to ACCUM.
  - IDLE & in_valid=0: stay in IDLE.
  - ACCUM & in_valid=1 & count<31: count+1, sum+=sext(in_result), signed max/min update; stay in ACCUM.
  - ACCUM & in_valid=1 & count==31: push the current record. Reload the accumulators with this sample (count=1) in the same cycle. Stay in ACCUM, so a back-to-back burst is split at 31 samples.
  - ACCUM & in_valid=0: push the current record; go to IDLE.
- Latency: last sample at cycle t, in_valid low at t+1, record written at the end of t+1, out_valid=1 during t+2 if the queue was empty.
- Arithmetic:
  - All comparisons are signed.
  - The sum uses a 12-bit signed accumulator. 31 × (−64) = −1984 and 31 × 63 = 1953 both fit, so no saturation logic is needed.
- Queue:
  - out_valid = !empty; head fields drive the outputs directly.
  - Pop on out_valid & out_ready.
  - Push while full with a simultaneous pop: accepted, no drop.
  - Push while full without a pop: record dropped, overflow←1. overflow stays set until rst.
  - FIFO order is preserved.
- Output stability: while out_valid=1 and out_ready=0, all out_* fields hold constant.
- Empty queue: out_* data fields hold their last value (0 after reset); the consumer ignores them.
- in_result is ignored when in_valid=0.

Decomposition:
- Package result_stats_pkg holds:
  - DATA_W, CNT_W, SUM_W=DATA_W+CNT_W, QDEPTH localparams.
  - stats_rec_t packed struct {count, sum, max, min}.
  - state_t enum {IDLE, ACCUM}.
- One sub-module, stats_fifo: a QDEPTH-entry synchronous FIFO of stats_rec_t with push, pop, full, empty and a head output. Its reset is also synchronous, active-high.
- Top level holds the FSM, the accumulators and the overflow flag.

Test Plan:
- Burst 3, −5, 7, then in_valid=0, out_ready=1 → one record count=3, sum=5, max=7, min=−5. out_valid is high 2 cycles after the last sample, for exactly 1 cycle.
- Single sample −64 → count=1, sum=−64, max=min=−64.
- 33 consecutive samples (31 of −64, then 1, 1) → record A: count=31, sum=−1984, max=min=−64. Record B: count=2, sum=2, max=min=1.
- out_ready=0; three 1-sample bursts (5, 6, 7) separated by idle cycles → queue holds 5 and 6, 7 is dropped, overflow=1. Raising out_ready pops 5 then 6; overflow stays 1.
- Queue full (out_ready=0), then a burst closes in the same cycle out_ready goes to 1 → head popped, new record accepted, overflow stays 0.
- rst pulsed for 1 cycle after 2 samples of a burst → out_valid=0, outputs 0. Next burst 4, 4 → record count=2, sum=8.

Source files
------------

// File: rtl/result_burst_stats_pkg.sv
// Shared widths, record layout and FSM encoding for the burst statistics block.
package result_stats_pkg;
    localparam int DATA_W = 7;
    localparam int CNT_W  = 5;
    localparam int SUM_W  = DATA_W + CNT_W;
    localparam int QDEPTH = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic        [CNT_W-1:0]  count;
        logic signed [SUM_W-1:0]  sum;
        logic signed [DATA_W-1:0] max;
        logic signed [DATA_W-1:0] min;
    } stats_rec_t;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;
endpackage

// File: rtl/result_burst_stats_if.sv
// Upstream result stream in, per-burst record stream out.
interface result_burst_stats_if;
    import result_stats_pkg::*;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_result;
    logic                     out_valid;
    logic                     out_ready;
    logic        [CNT_W-1:0]  out_count;
    logic signed [SUM_W-1:0]  out_sum;
    logic signed [DATA_W-1:0] out_max;
    logic signed [DATA_W-1:0] out_min;
    logic                     overflow;

    modport slave (
        input  in_valid, in_result, out_ready,
        output out_valid, out_count, out_sum, out_max, out_min, overflow
    );

    modport master (
        output in_valid, in_result, out_ready,
        input  out_valid, out_count, out_sum, out_max, out_min, overflow
    );
endinterface

// File: rtl/result_burst_stats_fifo.sv
// QDEPTH-entry record FIFO; the head holds the last popped record while empty.
module stats_fifo
    import result_stats_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  stats_rec_t wr_data,
    output stats_rec_t head,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int OCC_W = $clog2(QDEPTH + 1);

    stats_rec_t       mem [QDEPTH];
    stats_rec_t       last_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == OCC_W'(QDEPTH));
    assign do_pop  = pop && !empty;
    // a full queue still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/result_burst_stats.sv
// Groups consecutive valid results into bursts (split at 31 samples) and
// queues count/sum/max/min records for a consumer with backpressure.
module result_burst_stats
    import result_stats_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    result_burst_stats_if.slave  bus
);
    state_t     state_q;
    state_t     state_d;
    stats_rec_t acc_q;
    stats_rec_t acc_d;
    stats_rec_t first_rec;
    stats_rec_t merged_rec;
    stats_rec_t head;
    logic       rec_push;
    logic       q_full;
    logic       q_empty;
    logic       q_pop;
    logic       overflow_q;

    logic signed [DATA_W-1:0] din;
    logic signed [SUM_W-1:0]  din_ext;

    assign din     = bus.in_result;
    assign din_ext = {{CNT_W{din[DATA_W-1]}}, din};

    always_comb begin
        first_rec       = '0;
        first_rec.count = CNT_W'(1);
        first_rec.sum   = din_ext;
        first_rec.max   = din;
        first_rec.min   = din;

        merged_rec       = acc_q;
        merged_rec.count = acc_q.count + 1'b1;
        merged_rec.sum   = acc_q.sum + din_ext;
        if ($signed(din) > $signed(acc_q.max)) begin
            merged_rec.max = din;
        end
        if ($signed(din) < $signed(acc_q.min)) begin
            merged_rec.min = din;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rec_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = first_rec;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!bus.in_valid) begin
                    rec_push = 1'b1;
                    state_d  = IDLE;
                end else if (acc_q.count == CNT_MAX) begin
                    // full-length burst: emit it and start the next with this sample
                    rec_push = 1'b1;
                    acc_d    = first_rec;
                end else begin
                    acc_d = merged_rec;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (rec_push && q_full && !q_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign q_pop = !q_empty && bus.out_ready;

    stats_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rec_push),
        .pop     (q_pop),
        .wr_data (acc_q),
        .head    (head),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign bus.out_valid = !q_empty;
    assign bus.out_count = head.count;
    assign bus.out_sum   = head.sum;
    assign bus.out_max   = head.max;
    assign bus.out_min   = head.min;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_result_burst_stats.sv
// Directed and random stimulus against a queue-based burst statistics model.
module tb_result_burst_stats;
    import result_stats_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int         burst[$];
    stats_rec_t mq[$];
    stats_rec_t m_last;
    bit         m_ovf;

    result_burst_stats_if bus ();

    result_burst_stats dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stats_rec_t head_obs();
        stats_rec_t h;
        h.count = bus.out_count;
        h.sum   = bus.out_sum;
        h.max   = bus.out_max;
        h.min   = bus.out_min;
        return h;
    endfunction

    function automatic stats_rec_t mk(input int c, input int s, input int mx, input int mn);
        stats_rec_t r;
        r.count = CNT_W'(c);
        r.sum   = SUM_W'(s);
        r.max   = DATA_W'(mx);
        r.min   = DATA_W'(mn);
        return r;
    endfunction

    function automatic stats_rec_t summarize();
        int s  = 0;
        int mx = -1000;
        int mn = 1000;
        foreach (burst[i]) begin
            s += burst[i];
            if (burst[i] > mx) mx = burst[i];
            if (burst[i] < mn) mn = burst[i];
        end
        return mk(burst.size(), s, mx, mn);
    endfunction

    // Drives one cycle of inputs, compares outputs to the model, then advances.
    task automatic step(input bit v, input int r, input bit rdy);
        bit         pop;
        bit         close;
        stats_rec_t rec;
        bus.in_valid  = v;
        bus.in_result = DATA_W'(r);
        bus.out_ready = rdy;

        check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        check("head", 64'(head_obs()), (mq.size() != 0) ? 64'(mq[0]) : 64'(m_last));
        check("overflow", 64'(bus.overflow), 64'(m_ovf));

        pop   = (mq.size() != 0) && rdy;
        close = (burst.size() != 0) && (!v || burst.size() == 31);
        rec   = summarize();
        if (pop) begin
            m_last = mq[0];
            void'(mq.pop_front());
        end
        if (close) begin
            if (mq.size() < QDEPTH) mq.push_back(rec);
            else m_ovf = 1'b1;
            burst.delete();
        end
        if (v) burst.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        burst.delete();
        mq.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_head", 64'(head_obs()), 64'(0));
        check("rst_overflow", 64'(bus.overflow), 64'(0));
    endtask

    initial begin
        do_reset();

        // burst 3,-5,7
        step(1, 3, 1); step(1, -5, 1); step(1, 7, 1); step(0, 0, 1);
        check("b1_valid", 64'(bus.out_valid), 64'(1));
        check("b1_rec", 64'(head_obs()), 64'(mk(3, 5, 7, -5)));
        step(0, 0, 1);
        check("b1_one_cycle", 64'(bus.out_valid), 64'(0));

        // single sample at the negative limit
        step(1, -64, 1); step(0, 0, 1);
        check("single_rec", 64'(head_obs()), 64'(mk(1, -64, -64, -64)));
        step(0, 0, 1);

        // 33 back-to-back samples split at 31
        for (int i = 0; i < 31; i++) step(1, -64, 1);
        step(1, 1, 1);
        check("split_a", 64'(head_obs()), 64'(mk(31, -1984, -64, -64)));
        step(1, 1, 1); step(0, 0, 1);
        check("split_b", 64'(head_obs()), 64'(mk(2, 2, 1, 1)));
        step(0, 0, 1);

        // overflow: queue keeps 5 and 6, 7 is dropped
        step(1, 5, 0); step(0, 0, 0); step(1, 6, 0); step(0, 0, 0);
        step(1, 7, 0); step(0, 0, 0); step(0, 0, 0);
        check("ovf_set", 64'(bus.overflow), 64'(1));
        check("ovf_head5", 64'(head_obs()), 64'(mk(1, 5, 5, 5)));
        step(0, 0, 1);
        check("ovf_head6", 64'(head_obs()), 64'(mk(1, 6, 6, 6)));
        step(0, 0, 1); step(0, 0, 1);
        check("ovf_sticky", 64'(bus.overflow), 64'(1));

        // push into a full queue during a pop is accepted
        do_reset();
        step(1, 1, 0); step(0, 0, 0); step(1, 2, 0); step(0, 0, 0);
        step(1, 3, 0); step(0, 0, 1); step(0, 0, 0);
        check("full_pop_ovf", 64'(bus.overflow), 64'(0));
        check("full_pop_head", 64'(head_obs()), 64'(mk(1, 2, 2, 2)));
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);

        // reset mid-burst discards it
        step(1, 9, 1); step(1, 9, 1);
        do_reset();
        step(1, 4, 1); step(1, 4, 1); step(0, 0, 1);
        check("post_rst_rec", 64'(head_obs()), 64'(mk(2, 8, 4, 4)));
        step(0, 0, 1);

        // random traffic, mostly-ready then mostly-stalled consumer
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 8, int'($urandom_range(0, 127)) - 64, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 5, int'($urandom_range(0, 127)) - 64, $urandom_range(0, 3) == 0);
        for (int i = 0; i < 80; i++)
            step(1'b1, int'($urandom_range(0, 127)) - 64, 1'b1);
        for (int i = 0; i < 5; i++) step(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
